// File: rtl/vol_pkg.sv
// -----------------------------------------------------------------------------
// vol_pkg
// Shared constants and types for the microphone volume meter and the volume-bar
// renderer that consumes its output.
//
// Contents:
//   SAMPLE_W  - width of a raw mic sample (unsigned, idles at mid-scale)
//   BASE      - idle midpoint; samples at or below it are treated as silence
//   STEP_SH   - log2 of the level step size (128 counts per level)
//   LVL_W     - width of a volume level
//   LVL_MAX   - largest volume level (saturation point)
//   sample_t  - raw sample type
//   level_t   - volume level type, shared with the bar renderer so that the
//               width of `num` can never drift between producer and consumer
// -----------------------------------------------------------------------------
package vol_pkg;

   localparam int SAMPLE_W = 12;
   localparam int BASE     = 2048;
   localparam int STEP_SH  = 7;
   localparam int LVL_W    = 4;
   localparam int LVL_MAX  = 15;

   typedef logic [SAMPLE_W-1:0] sample_t;
   typedef logic [LVL_W-1:0]    level_t;

endpackage : vol_pkg

// File: rtl/vol_quant.sv
// -----------------------------------------------------------------------------
// vol_quant
// Purely combinational quantiser: maps a window peak to a volume level.
//
//   level = 0                                  when peak <= BASE
//   level = min(LVL_MAX, (peak - BASE) >> STEP_SH)  otherwise
//
// Integer floor, no rounding; saturates at LVL_MAX. Kept as its own block so a
// future peak-hold or multi-channel meter can instantiate the same mapping.
//
// Ports:
//   peak   (in,  SAMPLE_W) - unsigned peak sample to quantise
//   level  (out, LVL_W)    - resulting volume level 0..LVL_MAX
// -----------------------------------------------------------------------------
module vol_quant
   import vol_pkg::*;
(
   input  logic [SAMPLE_W-1:0] peak,
   output logic [LVL_W-1:0]    level
);

   localparam logic [SAMPLE_W-1:0] BASE_V    = SAMPLE_W'(BASE);
   localparam logic [SAMPLE_W-1:0] LVL_MAX_V = SAMPLE_W'(LVL_MAX);

   logic [SAMPLE_W-1:0] delta;
   logic [SAMPLE_W-1:0] steps;

   always_comb begin
      delta = '0;
      steps = '0;
      level = '0;
      if (peak > BASE_V) begin
         // peak > BASE here, so the subtraction cannot underflow.
         delta = peak - BASE_V;
         steps = delta >> STEP_SH;
         if (steps > LVL_MAX_V) begin
            level = LVL_W'(LVL_MAX);
         end else begin
            level = steps[LVL_W-1:0];
         end
      end
   end

endmodule : vol_quant

// File: rtl/vol_level_meter.sv
// -----------------------------------------------------------------------------
// vol_level_meter
// Turns the 20 kHz mic sample stream into a 4-bit volume level for the OLED
// volume bar. The running peak is tracked over WINDOW accepted samples; at the
// window's final sample the peak (including that final sample) is quantised
// and registered. Outputs hold steady between windows so the bar does not
// flicker per sample.
//
// Input strobe semantics: sample_en is a single-cycle qualifier with no
// back-pressure. mic_in is taken in every cycle where sample_en is high,
// including back-to-back cycles; each such cycle counts as exactly one sample.
// Cycles with sample_en low change nothing.
//
// Parameters:
//   WINDOW - accepted samples per window, legal range 2..65535
//   CNT_W  - window counter width, must hold WINDOW-1
//
// Ports:
//   clk        (in)           - system clock
//   rst        (in)           - synchronous active-high reset; wins over all
//                               other inputs and discards a partial window
//   sample_en  (in)           - sample strobe, mic_in valid this cycle
//   mic_in     (in, SAMPLE_W) - raw mic sample, unsigned, mid-scale idle
//   freeze     (in)           - at window end, block the output update; the
//                               next window still accumulates normally
//   num        (out, LVL_W)   - registered volume level 0..15
//   num_valid  (out)          - one-cycle pulse when num/peak were updated
//   peak       (out, SAMPLE_W)- registered window peak that produced num
// -----------------------------------------------------------------------------
module vol_level_meter
   import vol_pkg::*;
#(
   parameter int WINDOW = 4000,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sample_en,
   input  logic [SAMPLE_W-1:0] mic_in,
   input  logic                freeze,
   output logic [LVL_W-1:0]    num,
   output logic                num_valid,
   output logic [SAMPLE_W-1:0] peak
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

   // Window state: position within the window and the peak seen so far.
   logic [CNT_W-1:0]    cnt;
   logic [SAMPLE_W-1:0] run_max;

   // Peak including the sample presented this cycle, so the last sample of a
   // window lands in the latched peak without an extra cycle of latency.
   logic [SAMPLE_W-1:0] cand;
   logic [LVL_W-1:0]    cand_level;
   logic                window_end;

   always_comb begin
      cand = run_max;
      if (mic_in > run_max) begin
         cand = mic_in;
      end
   end

   assign window_end = sample_en && (cnt == CNT_LAST);

   vol_quant u_quant (
      .peak  (cand),
      .level (cand_level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         run_max   <= '0;
         num       <= '0;
         num_valid <= 1'b0;
         peak      <= '0;
      end else begin
         // Default low: the pulse lasts exactly one cycle. Since WINDOW >= 2,
         // two window ends can never fall on consecutive cycles.
         num_valid <= 1'b0;
         if (window_end) begin
            // Explicit wrap; the counter never passes WINDOW-1.
            cnt     <= '0;
            run_max <= '0;
            if (!freeze) begin
               peak      <= cand;
               num       <= cand_level;
               num_valid <= 1'b1;
            end
         end else if (sample_en) begin
            cnt     <= cnt + 1'b1;
            run_max <= cand;
         end
      end
   end

endmodule : vol_level_meter

// File: tb/tb_vol_level_meter.sv
// -----------------------------------------------------------------------------
// tb_vol_level_meter
// Directed bench for vol_level_meter with WINDOW=4. Inputs change on the
// falling edge; outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_vol_level_meter;

   logic        clk;
   logic        rst;
   logic        sample_en;
   logic [11:0] mic_in;
   logic        freeze;
   logic [3:0]  num;
   logic        num_valid;
   logic [11:0] peak;

   int n_asserts = 0;
   int n_fail    = 0;

   vol_level_meter #(
      .WINDOW (4),
      .CNT_W  (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sample_en (sample_en),
      .mic_in    (mic_in),
      .freeze    (freeze),
      .num       (num),
      .num_valid (num_valid),
      .peak      (peak)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One strobe, then sample_en drops; outputs sampled 1 ns after the edge.
   task automatic send(input int v, input logic frz);
      @(negedge clk);
      sample_en = 1'b1;
      mic_in    = 12'(v);
      freeze    = frz;
      @(posedge clk);
      #1;
      sample_en = 1'b0;
      freeze    = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_out(input string tag, input int e_num, input int e_peak, input int e_vld);
      check({tag, "_num"},   int'(num),       e_num);
      check({tag, "_peak"},  int'(peak),      e_peak);
      check({tag, "_valid"}, int'(num_valid), e_vld);
   endtask

   int pulses;
   int first_pulse;
   int last_pulse;
   int min_gap;

   initial begin
      rst       = 1'b1;
      sample_en = 1'b0;
      mic_in    = '0;
      freeze    = 1'b0;
      idle(2);
      @(negedge clk);
      rst = 1'b0;
      check_out("reset", 0, 0, 0);

      // 1: basic window
      send(2048, 0); send(2100, 0); send(2300, 0);
      check("t1_no_early_valid", int'(num_valid), 0);
      send(2200, 0);
      check_out("t1_end", 1, 2300, 1);
      idle(1);
      check_out("t1_hold", 1, 2300, 0);

      // 2: silence, saturation, boundary 14/15
      send(1000, 0); send(1500, 0); send(2000, 0); send(2048, 0);
      check_out("t2_silence", 0, 2048, 1);
      for (int i = 0; i < 4; i++) send(4095, 0);
      check_out("t2_sat", 15, 4095, 1);
      send(3967, 0); send(2000, 0); send(2000, 0); send(2000, 0);
      check_out("t2_lvl14", 14, 3967, 1);
      send(2000, 0); send(3968, 0); send(2000, 0); send(2000, 0);
      check_out("t2_lvl15", 15, 3968, 1);

      // 3: peak on last sample, then no carry-over
      send(2048, 0); send(2048, 0); send(2048, 0); send(3000, 0);
      check_out("t3_last", 7, 3000, 1);
      for (int i = 0; i < 4; i++) send(2048, 0);
      check_out("t3_clear", 0, 2048, 1);

      // 4: freeze at window end, then release
      send(3500, 0); send(2048, 0); send(2048, 0); send(2048, 1);
      check_out("t4_frozen", 0, 2048, 0);
      send(2600, 0); send(2100, 0); send(2048, 0); send(2000, 0);
      check_out("t4_release", 4, 2600, 1);

      // 5: reset mid-window
      send(4095, 0); send(4095, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_out("t5_after_rst", 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      send(2176, 0); send(2176, 0); send(2176, 0);
      check("t5_no_early_valid", int'(num_valid), 0);
      send(2176, 0);
      check_out("t5_end", 1, 2176, 1);

      // 6a: back-to-back strobes for 12 cycles, ramp 2048 + 128*i
      pulses = 0; first_pulse = -1; last_pulse = -1; min_gap = 1000;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         sample_en = 1'b1;
         mic_in    = 12'(2048 + 128 * i);
         @(posedge clk);
         #1;
         if (num_valid) begin
            pulses++;
            if (last_pulse >= 0 && (i - last_pulse) < min_gap) min_gap = i - last_pulse;
            if (first_pulse < 0) first_pulse = i;
            last_pulse = i;
         end
      end
      sample_en = 1'b0;
      check("t6_pulse_count", pulses, 3);
      check("t6_first_pulse", first_pulse, 3);
      check("t6_min_gap", min_gap, 4);
      check_out("t6_last_window", 11, 3456, 1);
      idle(1);
      check("t6_pulse_drop", int'(num_valid), 0);

      // 6b: random idle gaps between strobes do not change membership
      pulses = 0;
      send(2500, 0);
      for (int k = 0; k < 3; k++) begin
         int gap;
         gap = $urandom_range(0, 5);
         for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            if (num_valid) pulses++;
         end
         send((k == 0) ? 2300 : (k == 1) ? 2400 : 2200, 0);
         if (k < 2 && num_valid) pulses++;
      end
      check("t6_gap_no_early", pulses, 0);
      check_out("t6_gap_end", 3, 2500, 1);
      idle(3);
      check_out("t6_gap_hold", 3, 2500, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule : tb_vol_level_meter
